// File: rtl/alu_issue_stage_if.sv
// Handshake and data bundle between register-file read, the issue stage and the ALU.
interface alu_issue_stage_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  ALU_Control;
  logic        branch_op;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic [31:0] out_pc;
  logic        illegal;

  // Issue stage side
  modport slave (
    input  flush, in_valid, instruction, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, ALU_Control, branch_op, operand_A, operand_B,
           out_pc, illegal
  );

  // Upstream/downstream side (drives requests, consumes results)
  modport master (
    output flush, in_valid, instruction, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, ALU_Control, branch_op, operand_A, operand_B,
           out_pc, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes each accepted instruction into ALU control
// and operands, and holds results in a registered output with optional skid entry.
module alu_issue_stage #(
  parameter bit SKID_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  alu_issue_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic        br;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        ill;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b5;
  logic [31:0] imm_i, imm_s, imm_u;
  logic [1:0]  dec_blk;
  logic [2:0]  dec_f3;
  logic [31:0] dec_a, dec_b;
  logic        dec_br, dec_ill;
  entry_t      dec;
  logic        out_valid, in_ready, accept, xfer;

  assign opcode = bus.instruction[6:0];
  assign f3     = bus.instruction[14:12];
  assign f7b5   = bus.instruction[30];
  assign imm_i  = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
  assign imm_s  = {{20{bus.instruction[31]}}, bus.instruction[31:25], bus.instruction[11:7]};
  assign imm_u  = {bus.instruction[31:12], 12'b0};

  // Decode the incoming instruction into ALU block/funct3, operands and trap flag
  always_comb begin
    dec_blk = 2'b00;
    dec_f3  = 3'b000;
    dec_a   = '0;
    dec_b   = '0;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_blk = f7b5 ? 2'b01 : 2'b00;
        dec_f3  = f3;
        dec_a   = bus.rs1_data;
        dec_b   = bus.rs2_data;
      end
      OPC_OP_IMM: begin
        dec_blk = (f3 == 3'b101 && f7b5) ? 2'b01 : 2'b00;
        dec_f3  = f3;
        dec_a   = bus.rs1_data;
        dec_b   = imm_i;
        // SLLI with bit 30 set has no RV32I meaning
        if (f3 == 3'b001 && f7b5) dec_ill = 1'b1;
      end
      OPC_LOAD: begin
        dec_a = bus.rs1_data;
        dec_b = imm_i;
      end
      OPC_STORE: begin
        dec_a = bus.rs1_data;
        dec_b = imm_s;
      end
      OPC_BRANCH: begin
        dec_blk = 2'b10;
        dec_f3  = f3;
        dec_a   = bus.rs1_data;
        dec_b   = bus.rs2_data;
        dec_br  = 1'b1;
        if (f3 == 3'b010 || f3 == 3'b011) dec_ill = 1'b1;
      end
      OPC_JAL: begin
        dec_blk = 2'b11;
        dec_a   = bus.pc + 32'd4;
      end
      OPC_JALR: begin
        dec_blk = 2'b11;
        dec_a   = bus.pc + 32'd4;
        dec_b   = bus.rs1_data;
      end
      OPC_LUI: begin
        dec_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = bus.pc;
        dec_b = imm_u;
      end
      default: dec_ill = 1'b1;
    endcase
    // The alternate block only implements add/sub, shift-left and shift-right
    if (dec_blk == 2'b01 && dec_f3 != 3'b000 && dec_f3 != 3'b001 && dec_f3 != 3'b101)
      dec_ill = 1'b1;
    // Illegal entries still flow to execute, but with neutral control/operands
    if (dec_ill) begin
      dec_blk = 2'b00;
      dec_f3  = 3'b000;
      dec_a   = '0;
      dec_b   = '0;
      dec_br  = 1'b0;
    end
  end

  assign dec = '{ctrl: {1'b0, dec_blk, dec_f3}, br: dec_br, a: dec_a, b: dec_b,
                 pc: bus.pc, ill: dec_ill};

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign xfer      = out_valid && bus.out_ready;

  // Next-state for the output/skid registers; flush overrides all movement
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && xfer) begin
            main_d = dec;
          end else if (accept) begin
            if (SKID_EN) begin
              skid_d  = dec;
              state_d = ST_SKID;
            end
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (xfer) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_SKID);
  end

  // State and data registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.ALU_Control = main_q.ctrl;
  assign bus.branch_op   = main_q.br;
  assign bus.operand_A   = main_q.a;
  assign bus.operand_B   = main_q.b;
  assign bus.out_pc      = main_q.pc;
  assign bus.illegal     = main_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized bench for alu_issue_stage with a queue-based reference model.
module tb_alu_issue_stage;

  logic clock = 1'b0;
  logic reset = 1'b0;
  alu_issue_stage_if bus ();

  alu_issue_stage #(.SKID_EN(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  ctrl;
    logic        br;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [31:0] xfer_pcs[$];
  int          tests = 0;
  int          fails = 0;
  logic        acc_flag;

  // Reference decode written from the instruction-set rules with plain arithmetic
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int op, f3, blk, fn;
    bit alt, ok;
    logic [31:0] imm_i, imm_s, imm_u;
    op    = int'(ins[6:0]);
    f3    = int'(ins[14:12]);
    alt   = ins[30];
    imm_i = $signed(ins) >>> 20;
    imm_s = {imm_i[31:5], ins[11:7]};
    imm_u = ins & 32'hFFFF_F000;
    blk = 0; fn = 0; ok = 1'b1;
    e.a = 0; e.b = 0; e.br = 1'b0; e.pc = p;
    case (op)
      'h33: begin blk = alt ? 1 : 0; fn = f3; e.a = r1; e.b = r2; end
      'h13: begin
        blk = (f3 == 5 && alt) ? 1 : 0; fn = f3; e.a = r1; e.b = imm_i;
        if (f3 == 1 && alt) ok = 1'b0;
      end
      'h03: begin e.a = r1; e.b = imm_i; end
      'h23: begin e.a = r1; e.b = imm_s; end
      'h63: begin
        blk = 2; fn = f3; e.a = r1; e.b = r2; e.br = 1'b1;
        if (f3 == 2 || f3 == 3) ok = 1'b0;
      end
      'h6F: begin blk = 3; e.a = p + 4; e.b = 0; end
      'h67: begin blk = 3; e.a = p + 4; e.b = r1; end
      'h37: begin e.a = 0; e.b = imm_u; end
      'h17: begin e.a = p; e.b = imm_u; end
      default: ok = 1'b0;
    endcase
    if (blk == 1 && !(fn == 0 || fn == 1 || fn == 5)) ok = 1'b0;
    e.ill = !ok;
    if (ok) begin
      e.ctrl = 6'(blk * 8 + fn);
    end else begin
      e.ctrl = 0; e.a = 0; e.b = 0; e.br = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid    = v;
    bus.instruction = ins;
    bus.pc          = p;
    bus.rs1_data    = r1;
    bus.rs2_data    = r2;
  endtask

  // One clock cycle: check presented state against the model, then advance
  task automatic step();
    logic acc, xf;
    @(negedge clock);
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
    if (bus.out_valid && q.size() > 0) begin
      chk("ctrl", {26'b0, bus.ALU_Control}, {26'b0, q[0].ctrl});
      chk("branch_op", {31'b0, bus.branch_op}, {31'b0, q[0].br});
      chk("operand_A", bus.operand_A, q[0].a);
      chk("operand_B", bus.operand_B, q[0].b);
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("illegal", {31'b0, bus.illegal}, {31'b0, q[0].ill});
    end
    acc = bus.in_valid && bus.in_ready;
    xf  = bus.out_valid && bus.out_ready;
    if (xf) begin
      $display("[TB] xfer pc=%h ctrl=%h A=%h B=%h ill=%0b", bus.out_pc, bus.ALU_Control,
               bus.operand_A, bus.operand_B, bus.illegal);
      xfer_pcs.push_back(bus.out_pc);
      if (q.size() > 0) void'(q.pop_front());
    end
    if (bus.flush) begin
      q.delete();
      acc_flag = 1'b0;
    end else begin
      if (acc) q.push_back(model(bus.instruction, bus.pc, bus.rs1_data, bus.rs2_data));
      acc_flag = acc;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    int n;
    n = 0;
    drive(1'b1, ins, p, r1, r2);
    do begin
      step();
      n++;
    end while (!acc_flag && n < 20);
    chk("issue_accept", {31'b0, acc_flag}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() > 0 && n < 10) begin
      step();
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    chk({tag, "_ctrl"}, {26'b0, bus.ALU_Control}, 32'd0);
    chk({tag, "_branch_op"}, {31'b0, bus.branch_op}, 32'd0);
    chk({tag, "_operand_A"}, bus.operand_A, 32'd0);
    chk({tag, "_operand_B"}, bus.operand_B, 32'd0);
    chk({tag, "_out_pc"}, bus.out_pc, 32'd0);
    chk({tag, "_illegal"}, {31'b0, bus.illegal}, 32'd0);
  endtask

  logic [31:0] ops[10] = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63,
                           32'h6F, 32'h67, 32'h37, 32'h17, 32'h7F};
  logic [31:0] bp_ins[3] = '{32'h002081B3, 32'h402081B3, 32'h00209063};

  initial begin
    int cnt, n;
    logic [31:0] r, opv;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    acc_flag = 1'b0;

    // Power-on reset
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_values("reset");
    reset = 1'b0;

    // ADD then SUB
    bus.out_ready = 1'b1;
    issue(32'h002081B3, 32'h0000_0010, 32'd5, 32'd7);
    chk("add_ctrl", {26'b0, bus.ALU_Control}, 32'h00);
    chk("add_A", bus.operand_A, 32'd5);
    chk("add_B", bus.operand_B, 32'd7);
    issue(32'h402081B3, 32'h0000_0014, 32'd5, 32'd7);
    chk("sub_ctrl", {26'b0, bus.ALU_Control}, 32'h08);

    // Immediates
    issue(32'h40315093, 32'h18, 32'h1234, 32'h0);
    chk("srai_ctrl", {26'b0, bus.ALU_Control}, 32'h0D);
    chk("srai_shamt", {27'b0, bus.operand_B[4:0]}, 32'd3);
    issue(32'hFFF00093, 32'h1C, 32'h0, 32'h0);
    chk("addi_B", bus.operand_B, 32'hFFFF_FFFF);
    issue(32'h123450B7, 32'h20, 32'hDEAD, 32'hBEEF);
    chk("lui_A", bus.operand_A, 32'h0);
    chk("lui_B", bus.operand_B, 32'h1234_5000);

    // Branch and jumps, including PC wrap
    issue(32'h00209063, 32'h24, 32'h1, 32'h2);
    chk("bne_ctrl", {26'b0, bus.ALU_Control}, 32'h11);
    chk("bne_br", {31'b0, bus.branch_op}, 32'd1);
    issue(32'h000000EF, 32'h100, 32'h0, 32'h0);
    chk("jal_ctrl", {26'b0, bus.ALU_Control}, 32'h18);
    chk("jal_A", bus.operand_A, 32'h104);
    issue(32'h000000EF, 32'hFFFF_FFFC, 32'h0, 32'h0);
    chk("jal_wrap_A", bus.operand_A, 32'h0);

    // Illegal opcode
    issue(32'h0000007F, 32'h30, 32'h55, 32'h66);
    chk("ill_flag", {31'b0, bus.illegal}, 32'd1);
    chk("ill_ctrl", {26'b0, bus.ALU_Control}, 32'h0);
    chk("ill_A", bus.operand_A, 32'h0);
    chk("ill_B", bus.operand_B, 32'h0);
    chk("ill_br", {31'b0, bus.branch_op}, 32'h0);

    // Back-pressure: only two absorbed, then in-order release
    drain();
    xfer_pcs.delete();
    bus.out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bp_ins[cnt], 32'h200 + 32'(cnt) * 4, 32'(cnt + 1), 32'(cnt + 9));
      step();
      if (acc_flag) cnt++;
    end
    chk("bp_accepts", cnt, 2);
    chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    n = 0;
    while ((cnt < 3 || q.size() > 0) && n < 12) begin
      if (cnt < 3) drive(1'b1, bp_ins[cnt], 32'h200 + 32'(cnt) * 4, 32'(cnt + 1), 32'(cnt + 9));
      else bus.in_valid = 1'b0;
      step();
      if (acc_flag) cnt++;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("bp_xfer_count", xfer_pcs.size(), 3);
    if (xfer_pcs.size() == 3) begin
      chk("bp_order0", xfer_pcs[0], 32'h200);
      chk("bp_order1", xfer_pcs[1], 32'h204);
      chk("bp_order2", xfer_pcs[2], 32'h208);
    end

    // Flush while in the skid state with a same-cycle input
    drain();
    bus.out_ready = 1'b0;
    issue(32'h002081B3, 32'h300, 32'h1, 32'h2);
    issue(32'h402081B3, 32'h304, 32'h3, 32'h4);
    chk("flush_pre_in_ready", {31'b0, bus.in_ready}, 32'd0);
    xfer_pcs.delete();
    drive(1'b1, 32'h00209063, 32'h308, 32'h5, 32'h6);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("flush_no_output", xfer_pcs.size(), 0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      r   = $urandom();
      opv = ops[$urandom_range(0, 9)];
      drive(($urandom_range(0, 3) != 0), {r[31:7], opv[6:0]}, $urandom(), $urandom(), $urandom());
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    bus.flush = 1'b0;
    drain();

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    issue(32'h002081B3, 32'h400, 32'h7, 32'h8);
    issue(32'h00209063, 32'h404, 32'h9, 32'hA);
    #3 reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h123450B7, 32'h500, 32'h0, 32'h0);
    step();
    chk("post_reset_accept", {31'b0, acc_flag}, 32'd1);
    bus.in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage that drives the execute ALU. Each accepted RV32I instruction, with its PC and register-file read data, is decoded into the ALU's `ALU_Control` encoding, `branch_op` and operands `operand_A` and `operand_B`. Results are held in a registered output with a two-entry skid buffer, so upstream back-pressure (`in_ready`) is itself registered. The stage sits between the register-file read and the ALU.

## Interface
- `SKID_EN`, default 1: 1 = two-entry skid buffer; 0 = single register, with `in_ready = !out_valid || out_ready` (combinational).
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: discards all held entries and any same-cycle input.
- `in_valid` in 1: upstream has an instruction.
- `in_ready` out 1: stage can accept an instruction.
- `instruction` in 32: raw RV32I instruction.
- `pc` in 32: PC of the instruction.
- `rs1_data` in 32: register-file data for rs1.
- `rs2_data` in 32: register-file data for rs2.
- `out_valid` out 1: decoded entry is presented.
- `out_ready` in 1: ALU/execute consumes the entry.
- `ALU_Control` out 6: bit 5 is always 0; bits [4:3] are the ALU block; bits [2:0] are funct3.
- `branch_op` out 1: entry is a conditional branch.
- `operand_A` out 32: first ALU operand.
- `operand_B` out 32: second ALU operand.
- `out_pc` out 32: PC of the presented entry.
- `illegal` out 1: entry's opcode or funct combination is unsupported.

## Operation
- An input is accepted when `in_valid && in_ready`. A transfer out occurs when `out_valid && out_ready`.
- Decode by opcode, where `f3 = instr[14:12]` and `f7b5 = instr[30]`:
  - **OP (0110011):** block = `f7b5 ? 01 : 00`, funct3 = `f3`, A = `rs1`, B = `rs2`.
  - **OP-IMM (0010011):** block = `(f3==101 && f7b5) ? 01 : 00`, A = `rs1`, B = `sext(instr[31:20])`.
  - **LOAD (0000011):** block 00, funct3 000, A = `rs1`, B = I-immediate.
  - **STORE (0100011):** block 00, funct3 000, A = `rs1`, B = S-immediate `sext({instr[31:25], instr[11:7]})`.
  - **BRANCH (1100011):** block 10, funct3 = `f3`, A = `rs1`, B = `rs2`, `branch_op` = 1.
  - **JAL (1101111) and JALR (1100111):** block 11, funct3 000, A = `pc + 4` (mod 2^32), B = `rs1` for JALR and 0 for JAL.
  - **LUI (0110111):** block 00, funct3 000, A = 0, B = `{instr[31:12], 12'b0}`.
  - **AUIPC (0010111):** block 00, funct3 000, A = `pc`, B = `{instr[31:12], 12'b0}`.
- `illegal` = 1 in each of these cases:
  - any other opcode;
  - block 01 with funct3 not in {000, 001, 101};
  - OP-IMM with `f3 == 001` and `f7b5 == 1`;
  - BRANCH with `f3` equal to 010 or 011.
- When `illegal` = 1, the outputs are forced to `ALU_Control` = 0, A = 0, B = 0, `branch_op` = 0.
- The entry still flows through the stage so execute can trap on it.
- Skid states (`SKID_EN` = 1):
  - **EMPTY:** main register invalid.
  - **FULL:** main register valid.
  - **SKID:** main and skid registers both valid.
- Skid state transitions:
  - EMPTY → FULL on accept.
  - FULL → SKID on accept without transfer.
  - FULL → EMPTY on transfer without accept.
  - In FULL, simultaneous accept and transfer loads main and stays FULL.
  - SKID → FULL on transfer, when the skid register moves into main.
- `in_ready` is a register: 1 in EMPTY and FULL, 0 in SKID.
- Order is strictly FIFO.
- `flush` has priority over everything else:
  - next state is EMPTY;
  - any same-cycle accept is dropped;
  - `in_ready` is 1 on the next cycle.

## Timing
- Reset values: `out_valid` = 0, `in_ready` = 1, `ALU_Control` = 0, `branch_op` = 0, `operand_A` = 0, `operand_B` = 0, `out_pc` = 0, `illegal` = 0, state EMPTY.
- Latency: an input accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput: 1 instruction per cycle when `out_ready` is held at 1.
- Output data is stable while `out_valid && !out_ready`.
- Data fields are don't-care when `out_valid` = 0, but must not be X after reset.
- `in_ready` deasserts the cycle after entry into SKID. At most one extra instruction is absorbed.
- Reset asserted mid-stream returns the block to reset values immediately, without waiting for a clock edge. The first accept can occur on the first edge after reset deasserts.

## Test plan
- **ADD then SUB:** present ADD x3,x1,x2 (`0x002081B3`) with rs1 = 5, rs2 = 7, then SUB x3,x1,x2 (`0x402081B3`). Required: `ALU_Control` = 0x00 with A = 5, B = 7; then `ALU_Control` = 0x08.
- **Immediates:** SRAI x1,x2,3 (`0x40315093`) → `ALU_Control` = 0x0D, B[4:0] = 3. ADDI x1,x0,-1 → B = `0xFFFFFFFF`. LUI `0x12345` → A = 0, B = `0x12345000`.
- **Branch and jump:** BNE → `ALU_Control` = 0x11, `branch_op` = 1. JAL at pc `0x100` → `ALU_Control` = 0x18, A = `0x104`. JAL at pc `0xFFFFFFFC` → A = 0.
- **Back-pressure:** hold `out_ready` = 0 and stream 3 valid instructions. Required: 2 accepted, `in_ready` = 0 after the second. Then release `out_ready`: the outputs appear in order, with no loss or duplication.
- **Flush:** in SKID, assert `flush` together with `in_valid`. Required: next cycle `out_valid` = 0, `in_ready` = 1, and the flushed instructions never appear.
- **Illegal and reset:** opcode `0x7F` → `illegal` = 1 with zeroed control fields. Assert `reset` mid-stream → all outputs take their reset values immediately, with no clock edge needed.
